asym_fifo: RTL
==============

# asym_fifo

Single-clock, parametrised asymmetric-width FIFO: narrow writes (default 8-bit, CPU/bus side) packed into wide reads (default 16-bit, VGA fetch side), backed by an asymmetric simple-dual-port RAM. It generalises the fixed 4K×8 / 2K×16 video RAM into a flow-controlled buffer with configurable width, ratio and depth. It adds level counters, full/empty flags, sticky error flags and flush. It sits between the v65C02 bus interface and the VGA line/character fetch logic.

## Interface
- DW, 8, write data width in bits
- RATIO, 2, read width / write width; power of two, 1..8
- AW, 12, write-side address bits; depth = 2^AW narrow words = 2^AW/RATIO wide words
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  synchronous empty; same effect as rst_i on all state except memory contents
- wr_en_i  in  1  write request
- wr_data_i  in  DW  write data
- full_o  out  1  no free narrow slot
- rd_en_i  in  1  read request
- rd_data_o  out  DW*RATIO  read data, registered
- rd_valid_o  out  1  rd_data_o updated this cycle
- empty_o  out  1  fewer than RATIO narrow words stored
- wr_level_o  out  AW+1  narrow words stored, 0..2^AW
- overflow_o  out  1  sticky, write attempted while full
- underflow_o  out  1  sticky, read attempted while empty

## Operation
- Pointers: wr_ptr AW+1 bits (narrow units); rd_ptr AW-log2(RATIO)+1 bits (wide units); MSB is the wrap bit; both wrap modulo 2× range.
- Level = wr_ptr − (rd_ptr << log2(RATIO)), computed modulo 2^(AW+1); full when level = 2^AW; empty when level < RATIO.
- Write accepted iff wr_en_i && !full_o; data stored at wr_ptr[AW-1:0]; wr_ptr += 1.
- Read accepted iff rd_en_i && !empty_o; RAM wide word at rd_ptr[low bits] loaded into rd_data_o; rd_ptr += 1.
- Packing little-endian: earliest-written narrow word occupies rd_data_o[DW-1:0].
- Partial wide word (level mod RATIO ≠ 0) is not readable; empty_o stays 1 while level < RATIO.
- Rejected write (full) sets overflow_o, no state change. Rejected read (empty) sets underflow_o, rd_valid_o=0, rd_data_o holds.
- Simultaneous read and write: each qualified against the flags registered at the start of the cycle; both may complete; at full, the write is dropped even if a read completes.
- Priority: rst_i > flush_i > wr/rd. Flush with wr_en_i/rd_en_i asserted: requests discarded, no flag set.
- Reset/flush values: pointers 0, wr_level_o 0, empty_o 1, full_o 0, rd_valid_o 0, rd_data_o 0, overflow_o 0, underflow_o 0. RAM contents undefined/retained.

## Timing
- All outputs registered; flags and wr_level_o reflect operations accepted at edge N starting after edge N.
- Read latency 1: rd_en_i accepted at edge N → rd_data_o/rd_valid_o valid after edge N, for exactly one cycle (rd_valid_o).
- Write-to-read: write completing a wide word at edge N → empty_o=0 after N → read accepted at N+1 returns that word.
- Read-to-write: read at edge N frees slots; full_o drops after N; write accepted at N+1.
- Back-to-back accesses sustain one narrow write and one wide read per cycle.
- Read never targets a wide word under partial write, so no RAM read-during-write hazard.

## Structure
- Shared package (v65C02 common defines include): clog2 function, default DW/RATIO/AW for the VGA buffer.
- Sub-module ram_asym_1clk: single-clock simple-dual-port RAM, DW-wide write port, DW*RATIO-wide registered read port with enable; infers block RAM; no reset on array.
- asym_fifo holds pointers, level, flags and error logic only.

## Test plan
- Reset, write 0x01 then 0x02, read → rd_data_o=0x0201 one cycle after rd_en_i, rd_valid_o one cycle wide, empty_o=1 after.
- Write 0xA0,0xA1,0xA2, read → 0xA1A0; then wr_level_o=1, empty_o=1; second read rejected, underflow_o=1, rd_data_o holds 0xA1A0.
- Write 4096 bytes (i & 0xFF) → full_o=1, wr_level_o=4096; extra write 0xFF → overflow_o=1, level unchanged; drain 2048 reads match pattern.
- At full, wr_en_i and rd_en_i same cycle → read returns oldest word, write dropped, wr_level_o=4094, overflow_o=1.
- Three fill/drain passes of 3000 bytes with random concurrent rd/wr → pointers wrap, scoreboard matches, no spurious flags.
- Flush with level 10 and wr_en_i=1 → next cycle level 0, empty_o=1, flags 0; rst_i mid-stream → same.

Source files
------------

// File: rtl/asym_fifo_pkg.sv
// Shared definitions for the asymmetric-width FIFO and its RAM.
package asym_fifo_pkg;

  // Default geometry of the VGA fetch buffer: 4K x 8 written, 2K x 16 read.
  localparam int unsigned VGA_DW    = 8;
  localparam int unsigned VGA_RATIO = 2;
  localparam int unsigned VGA_AW    = 12;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_asym_1clk.sv
// Single-clock simple-dual-port RAM: narrow write port, wide registered read port.
module ram_asym_1clk
  import asym_fifo_pkg::*;
#(
  parameter int unsigned DW    = VGA_DW,
  parameter int unsigned RATIO = VGA_RATIO,
  parameter int unsigned AW    = VGA_AW,
  localparam int unsigned RAW  = AW - clog2(RATIO)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DW-1:0]         wdata,
  input  logic                  re,
  input  logic [RAW-1:0]        raddr,
  output logic [DW*RATIO-1:0]   rdata
);

  localparam int unsigned LR = clog2(RATIO);
  localparam int unsigned LW = (LR > 0) ? LR : 1;

  // Each row holds one wide word; lane 0 is the earliest narrow word.
  typedef logic [RATIO-1:0][DW-1:0] row_t;

  row_t             mem [2**RAW];
  logic [RAW-1:0]   wrow;
  logic [LW-1:0]    wlane;

  // Split the narrow write address into wide row and lane.
  always_comb begin
    wrow  = RAW'(waddr >> LR);
    wlane = LW'(waddr & AW'(RATIO - 1));
  end

  // Lane write into the array; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wrow][wlane] <= wdata;
  end

  // Registered wide read with enable; output register clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/asym_fifo.sv
// Flow-controlled FIFO packing narrow writes into wide reads.
module asym_fifo
  import asym_fifo_pkg::*;
#(
  parameter int unsigned DW    = VGA_DW,
  parameter int unsigned RATIO = VGA_RATIO,
  parameter int unsigned AW    = VGA_AW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                wr_en_i,
  input  logic [DW-1:0]       wr_data_i,
  output logic                full_o,
  input  logic                rd_en_i,
  output logic [DW*RATIO-1:0] rd_data_o,
  output logic                rd_valid_o,
  output logic                empty_o,
  output logic [AW:0]         wr_level_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int unsigned LR  = clog2(RATIO);
  localparam int unsigned RAW = AW - LR;
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned RPW = RAW + 1;

  logic [AW:0]  wr_ptr, wr_ptr_nxt;
  logic [RAW:0] rd_ptr, rd_ptr_nxt;
  logic [AW:0]  level_nxt;
  logic         clr, wr_ok, rd_ok;

  // Qualify requests against the registered flags and form the next level.
  always_comb begin
    clr        = rst_i | flush_i;
    wr_ok      = wr_en_i & ~full_o & ~clr;
    rd_ok      = rd_en_i & ~empty_o & ~clr;
    wr_ptr_nxt = wr_ptr + PW'(wr_ok);
    rd_ptr_nxt = rd_ptr + RPW'(rd_ok);
    level_nxt  = wr_ptr_nxt - (PW'(rd_ptr_nxt) << LR);
  end

  // Pointers, level, flags and sticky errors.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_level_o  <= '0;
      full_o      <= 1'b0;
      empty_o     <= 1'b1;
      rd_valid_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_level_o  <= level_nxt;
      full_o      <= (level_nxt == {1'b1, {AW{1'b0}}});
      empty_o     <= (level_nxt < PW'(RATIO));
      rd_valid_o  <= rd_ok;
      overflow_o  <= overflow_o | (wr_en_i & full_o);
      underflow_o <= underflow_o | (rd_en_i & empty_o);
    end
  end

  // Backing store; a read never hits a row under partial write.
  ram_asym_1clk #(
    .DW    (DW),
    .RATIO (RATIO),
    .AW    (AW)
  ) u_ram (
    .clk   (clk_i),
    .rst   (clr),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data_i),
    .re    (rd_ok),
    .raddr (rd_ptr[RAW-1:0]),
    .rdata (rd_data_o)
  );

endmodule
